// File: rtl/nf10_axis_rr_output_arbiter.sv
// Packet-granular round-robin arbiter: shares one AXI4-Stream master between
// C_NUM_INPUTS slave streams, holding each grant until the packet's tlast beat.
module nf10_axis_rr_output_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_INPUTS       = 4,
    parameter int C_CNT_WIDTH        = 32
) (
    input  logic                                          aclk,
    input  logic                                          areset,
    input  logic [C_NUM_INPUTS*C_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_NUM_INPUTS*C_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
    input  logic [C_NUM_INPUTS*C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic [C_NUM_INPUTS-1:0]                       s_axis_tvalid,
    input  logic [C_NUM_INPUTS-1:0]                       s_axis_tlast,
    output logic [C_NUM_INPUTS-1:0]                       s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]                  m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]                m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]                 m_axis_tuser,
    output logic                                          m_axis_tvalid,
    output logic                                          m_axis_tlast,
    input  logic                                          m_axis_tready,
    input  logic [C_NUM_INPUTS-1:0]                       input_enable,
    output logic [C_NUM_INPUTS-1:0]                       grant_onehot,
    output logic [C_NUM_INPUTS*C_CNT_WIDTH-1:0]           pkt_count
);

    localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;
    localparam int IDX_W  = (C_NUM_INPUTS > 1) ? $clog2(C_NUM_INPUTS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
    logic [C_NUM_INPUTS-1:0] grant_q, grant_d;
    logic [C_NUM_INPUTS-1:0] req;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_found;
    logic [C_CNT_WIDTH-1:0]  cnt_q [C_NUM_INPUTS];

    logic [C_AXIS_DATA_WIDTH-1:0]  g_data;
    logic [STRB_W-1:0]             g_strb;
    logic [C_AXIS_TUSER_WIDTH-1:0] g_user;
    logic                          g_valid;
    logic                          g_last;
    logic                          beat_xfer;
    logic                          pkt_done;

    assign req = s_axis_tvalid & input_enable;

    // Search starts one past the previous winner and wraps, so the last
    // winner is considered only when nobody else is requesting.
    always_comb begin
        int unsigned cand;
        logic [IDX_W-1:0] cand_idx;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 1; k <= int'(C_NUM_INPUTS); k++) begin
            cand     = (32'(last_grant_q) + k) % int'(C_NUM_INPUTS);
            cand_idx = IDX_W'(cand);
            if (!arb_found && req[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    assign g_data  = s_axis_tdata[grant_idx_q*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
    assign g_strb  = s_axis_tstrb[grant_idx_q*STRB_W +: STRB_W];
    assign g_user  = s_axis_tuser[grant_idx_q*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
    assign g_valid = s_axis_tvalid[grant_idx_q];
    assign g_last  = s_axis_tlast[grant_idx_q];

    assign beat_xfer = (state_q == PASS) && g_valid && m_axis_tready;
    assign pkt_done  = beat_xfer && g_last;

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (state_q == PASS) begin
            m_axis_tdata               = g_data;
            m_axis_tstrb               = g_strb;
            m_axis_tuser               = g_user;
            m_axis_tvalid              = g_valid;
            m_axis_tlast               = g_last;
            s_axis_tready[grant_idx_q] = m_axis_tready;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        grant_idx_d  = grant_idx_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d     = PASS;
                    grant_d     = C_NUM_INPUTS'(1) << arb_idx;
                    grant_idx_d = arb_idx;
                end
            end
            PASS: begin
                if (pkt_done) begin
                    state_d      = IDLE;
                    grant_d      = '0;
                    last_grant_d = grant_idx_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            grant_idx_q  <= '0;
            last_grant_q <= IDX_W'(C_NUM_INPUTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            grant_idx_q  <= grant_idx_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int unsigned i = 0; i < int'(C_NUM_INPUTS); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < int'(C_NUM_INPUTS); i++) begin
                if (pkt_done && (grant_idx_q == IDX_W'(i))) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign grant_onehot = grant_q;

    for (genvar gi = 0; gi < C_NUM_INPUTS; gi++) begin : g_cnt_out
        assign pkt_count[gi*C_CNT_WIDTH +: C_CNT_WIDTH] = cnt_q[gi];
    end

endmodule

// File: tb/tb_nf10_axis_rr_output_arbiter.sv
// Directed bench for nf10_axis_rr_output_arbiter: per-input source queues feed
// the DUT, expected output beats are queued in predicted grant order.
module tb_nf10_axis_rr_output_arbiter;

    localparam int DW = 256;
    localparam int SW = DW / 8;
    localparam int UW = 128;
    localparam int N  = 4;
    localparam int CW = 4;

    logic                aclk = 1'b0;
    logic                areset;
    logic [N*DW-1:0]     s_axis_tdata;
    logic [N*SW-1:0]     s_axis_tstrb;
    logic [N*UW-1:0]     s_axis_tuser;
    logic [N-1:0]        s_axis_tvalid;
    logic [N-1:0]        s_axis_tlast;
    logic [N-1:0]        s_axis_tready;
    logic [DW-1:0]       m_axis_tdata;
    logic [SW-1:0]       m_axis_tstrb;
    logic [UW-1:0]       m_axis_tuser;
    logic                m_axis_tvalid;
    logic                m_axis_tlast;
    logic                m_axis_tready;
    logic [N-1:0]        input_enable;
    logic [N-1:0]        grant_onehot;
    logic [N*CW-1:0]     pkt_count;

    nf10_axis_rr_output_arbiter #(
        .C_AXIS_DATA_WIDTH  (DW),
        .C_AXIS_TUSER_WIDTH (UW),
        .C_NUM_INPUTS       (N),
        .C_CNT_WIDTH        (CW)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .input_enable  (input_enable),
        .grant_onehot  (grant_onehot),
        .pkt_count     (pkt_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
        int unsigned   src;
    } beat_t;

    beat_t           src_q [N][$];
    beat_t           exp_q [$];
    logic [CW-1:0]   cnt_exp [N];
    int unsigned     n_cmp = 0;
    int unsigned     n_fail = 0;

    logic [N-1:0]    obs_grant;
    logic [N-1:0]    obs_s_tready;
    logic            obs_mvalid;
    logic [DW-1:0]   obs_mdata;
    logic [N-1:0]    tready_seen;
    logic [N-1:0]    grant_seen;
    logic [N-1:0]    pop_pend;
    logic [DW-1:0]   stall_data;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int unsigned s);
        oh = N'(1) << s;
    endfunction

    function automatic logic [N*CW-1:0] cnt_flat();
        logic [N*CW-1:0] f;
        f = '0;
        for (int i = 0; i < N; i++) f[i*CW +: CW] = cnt_exp[i];
        return f;
    endfunction

    task automatic drive_sources();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                s_axis_tvalid[i]           = 1'b1;
                s_axis_tdata[i*DW +: DW]   = src_q[i][0].data;
                s_axis_tstrb[i*SW +: SW]   = src_q[i][0].strb;
                s_axis_tuser[i*UW +: UW]   = src_q[i][0].user;
                s_axis_tlast[i]            = src_q[i][0].last;
            end else begin
                s_axis_tvalid[i]           = 1'b0;
                s_axis_tdata[i*DW +: DW]   = '0;
                s_axis_tstrb[i*SW +: SW]   = '0;
                s_axis_tuser[i*UW +: UW]   = '0;
                s_axis_tlast[i]            = 1'b0;
            end
        end
    endtask

    // One clock: sample/score at negedge, then advance sources just after posedge.
    task automatic tick();
        beat_t eb;
        @(negedge aclk);
        obs_grant    = grant_onehot;
        obs_s_tready = s_axis_tready;
        obs_mvalid   = m_axis_tvalid;
        obs_mdata    = m_axis_tdata;
        tready_seen  = tready_seen | s_axis_tready;
        grant_seen   = grant_seen | grant_onehot;
        pop_pend     = s_axis_tvalid & s_axis_tready;
        if (m_axis_tvalid && m_axis_tready) begin
            chk("beat_expected", 512'(exp_q.size() > 0), 512'(1));
            if (exp_q.size() > 0) begin
                eb = exp_q.pop_front();
                chk("out_beat",
                    512'({m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast, grant_onehot}),
                    512'({eb.data, eb.strb, eb.user, eb.last, oh(eb.src)}));
            end
        end
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (pop_pend[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        drive_sources();
    endtask

    task automatic enqueue(input int unsigned s, input int unsigned nb, input bit expect_out, input bit count);
        beat_t b;
        for (int unsigned k = 0; k < nb; k++) begin
            for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
            b.strb = $urandom;
            for (int w = 0; w < UW / 32; w++) b.user[w*32 +: 32] = $urandom;
            b.last = (k == nb - 1);
            b.src  = s;
            src_q[s].push_back(b);
            if (expect_out) exp_q.push_back(b);
        end
        if (count) cnt_exp[s] = cnt_exp[s] + 1'b1;
    endtask

    task automatic drain(input string tag, input int unsigned budget);
        int unsigned c = 0;
        while (exp_q.size() > 0 && c < budget) begin
            tick();
            c++;
        end
        chk({tag, "_drain"}, 512'(exp_q.size()), 512'(0));
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        areset = 1'b1;
        clear_sources();
        for (int i = 0; i < N; i++) cnt_exp[i] = '0;
        m_axis_tready = 1'b1;
        input_enable  = '1;
        tick();
        tick();
        chk("rst_grant",  512'(obs_grant),    512'(0));
        chk("rst_tready", 512'(obs_s_tready), 512'(0));
        chk("rst_count",  512'(pkt_count),    512'(0));
        areset      = 1'b0;
        tready_seen = '0;
        grant_seen  = '0;
    endtask

    initial begin
        areset        = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        input_enable  = '1;
        tready_seen   = '0;
        grant_seen    = '0;
        pop_pend      = '0;

        // Reset with traffic pending: outputs must stay quiet.
        enqueue(0, 2, 1'b0, 1'b0);
        enqueue(2, 2, 1'b0, 1'b0);
        drive_sources();
        tick();
        chk("rst_mvalid", 512'(obs_mvalid), 512'(0));
        chk("rst_mdata",  512'(obs_mdata),  512'(0));
        do_reset();

        // Inputs 0 and 2 contend: 0 first, one bubble, then 2.
        enqueue(0, 3, 1'b1, 1'b1);
        enqueue(2, 3, 1'b1, 1'b1);
        drive_sources();
        tick();
        chk("t1_arb_cycle_grant", 512'(obs_grant), 512'(0));
        chk("t1_arb_cycle_valid", 512'(obs_mvalid), 512'(0));
        tick();
        chk("t1_first_grant", 512'(obs_grant), 512'(4'b0001));
        tick();
        tick();
        tick();
        chk("t1_bubble_grant", 512'(obs_grant), 512'(0));
        chk("t1_bubble_valid", 512'(obs_mvalid), 512'(0));
        drain("t1", 20);
        chk("t1_counts", 512'(pkt_count), 512'(cnt_flat()));

        // Back-to-back single-beat packets on all inputs: 0,1,2,3 x4.
        do_reset();
        for (int r = 0; r < 4; r++)
            for (int unsigned i = 0; i < N; i++) enqueue(i, 1, 1'b1, 1'b1);
        drive_sources();
        drain("t2", 100);
        chk("t2_counts", 512'(pkt_count), 512'(cnt_flat()));

        // Backpressure on beat 2 of a 4-beat packet from input 1.
        do_reset();
        enqueue(1, 4, 1'b1, 1'b1);
        drive_sources();
        tick();
        tick();
        chk("t3_grant", 512'(obs_grant), 512'(4'b0010));
        tick();
        stall_data    = exp_q[0].data;
        m_axis_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_stall_data",   512'(obs_mdata),    512'(stall_data));
            chk("t3_stall_tready", 512'(obs_s_tready), 512'(0));
        end
        m_axis_tready = 1'b1;
        drain("t3", 20);
        chk("t3_counts", 512'(pkt_count), 512'(cnt_flat()));

        // Input 2 masked off while requesting.
        do_reset();
        input_enable = 4'b1011;
        for (int r = 0; r < 2; r++) begin
            enqueue(0, 1, 1'b1, 1'b1);
            enqueue(1, 1, 1'b1, 1'b1);
            enqueue(2, 1, 1'b0, 1'b0);
            enqueue(3, 1, 1'b1, 1'b1);
        end
        drive_sources();
        drain("t4", 60);
        for (int k = 0; k < 3; k++) tick();
        chk("t4_in2_tready", 512'(tready_seen[2]), 512'(0));
        chk("t4_in2_grant",  512'(grant_seen[2]),  512'(0));
        chk("t4_counts", 512'(pkt_count), 512'(cnt_flat()));

        // Clearing enable mid-packet keeps the grant; input 1 then skipped.
        do_reset();
        enqueue(1, 3, 1'b1, 1'b1);
        enqueue(3, 2, 1'b1, 1'b1);
        enqueue(1, 2, 1'b0, 1'b0);
        drive_sources();
        tick();
        input_enable = 4'b1101;
        drain("t4b", 30);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4b_idle_grant", 512'(obs_grant), 512'(0));
        end
        chk("t4b_counts", 512'(pkt_count), 512'(cnt_flat()));

        // Reset asserted on beat 3 of a 5-beat packet from input 3.
        do_reset();
        enqueue(3, 5, 1'b1, 1'b0);
        drive_sources();
        tick();
        tick();
        tick();
        chk("t5_mid_grant", 512'(grant_onehot), 512'(4'b1000));
        areset = 1'b1;
        tick();
        chk("t5_rst_valid", 512'(obs_mvalid), 512'(0));
        chk("t5_rst_grant", 512'(obs_grant),  512'(0));
        clear_sources();
        chk("t5_rst_count", 512'(pkt_count), 512'(0));
        areset = 1'b0;
        enqueue(0, 1, 1'b1, 1'b1);
        enqueue(3, 1, 1'b1, 1'b1);
        drive_sources();
        drain("t5", 20);
        chk("t5_counts", 512'(pkt_count), 512'(cnt_flat()));

        // Counter wrap on a 4-bit counter.
        do_reset();
        for (int k = 0; k < 15; k++) enqueue(0, 1, 1'b1, 1'b1);
        drive_sources();
        drain("t6a", 100);
        chk("t6_count15", 512'(pkt_count), 512'(cnt_flat()));
        enqueue(0, 1, 1'b1, 1'b1);
        drive_sources();
        drain("t6b", 20);
        chk("t6_wrap", 512'(pkt_count[CW-1:0]), 512'(cnt_exp[0]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
